// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared sizing for the CIC decimation filter. The integrator/decimator and
// the downstream comb stages both derive their accumulator width from
// cic_acc_width() so the two halves always wrap modulo the same 2^ACC_WIDTH.
// No ports (package).
// -----------------------------------------------------------------------------
package cic_pkg;

   localparam int NUM_STAGES_MAX = 6;
   localparam int DECIM_MAX      = 256;

   // Bit growth of an N-stage, rate-R CIC is N*ceil(log2(R)) on top of the input.
   function automatic int cic_acc_width(input int data_width,
                                        input int num_stages,
                                        input int decim_log2);
      return data_width + (num_stages * decim_log2);
   endfunction

endpackage

// File: rtl/cic_integrator.sv
// -----------------------------------------------------------------------------
// cic_integrator
// One modular (wrap-around) accumulator stage of the CIC integrator cascade.
// Optional synchronous clear is compiled in with `define CIC_INTEG_SYNC_CLR_EN.
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset, clears the accumulator
//   sclr  in   synchronous clear (only with CIC_INTEG_SYNC_CLR_EN), beats en
//   en    in   accumulate enable (one input sample)
//   din   in   ACC_WIDTH addend (sign-extended sample or previous stage)
//   acc   out  ACC_WIDTH registered accumulator value
// -----------------------------------------------------------------------------
module cic_integrator
   import cic_pkg::*;
#(
   parameter int ACC_WIDTH = cic_acc_width(16, 3, 3)
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef CIC_INTEG_SYNC_CLR_EN
   input  logic                 sclr,
`endif
   input  logic                 en,
   input  logic [ACC_WIDTH-1:0] din,
   output logic [ACC_WIDTH-1:0] acc
);

   localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

   logic                 clr_s;
   logic [ACC_WIDTH-1:0] sum_s;
   logic [ACC_WIDTH-1:0] acc_r;

`ifdef CIC_INTEG_SYNC_CLR_EN
   assign clr_s = sclr;
`else
   assign clr_s = 1'b0;
`endif

   // Modular sum: overflow wraps silently, the combs undo it.
   always_comb begin
      sum_s = acc_r + din;
   end

   // Accumulator register: clear has priority over accumulate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= ACC_ZERO;
      end else if (clr_s) begin
         acc_r <= ACC_ZERO;
      end else if (en) begin
         acc_r <= sum_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   assign acc = acc_r;

endmodule

// File: rtl/cic_integ_decim.sv
// -----------------------------------------------------------------------------
// cic_integ_decim
// Integrator + decimator front half of a CIC decimation filter. NUM_STAGES
// pipelined integrators run at the input rate; every DECIM-th valid sample
// the post-update value of the last integrator is registered to out_data
// together with a one-cycle out_valid pulse. No backpressure.
// Optional synchronous clear port sclr: `define CIC_INTEG_SYNC_CLR_EN.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   sclr       in   synchronous clear (only with CIC_INTEG_SYNC_CLR_EN)
//   in_valid   in   input sample strobe
//   in_data    in   DATA_WIDTH signed input sample
//   out_valid  out  decimated sample strobe, one-cycle pulse
//   out_data   out  ACC_WIDTH signed decimated integrator output
// -----------------------------------------------------------------------------
module cic_integ_decim
   import cic_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int NUM_STAGES = 3,
   parameter  int DECIM      = 8,
   parameter  int DECIM_LOG2 = 3,
   localparam int ACC_WIDTH  = cic_acc_width(DATA_WIDTH, NUM_STAGES, DECIM_LOG2)
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef CIC_INTEG_SYNC_CLR_EN
   input  logic                  sclr,
`endif
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [ACC_WIDTH-1:0]  out_data
);

   localparam logic [DECIM_LOG2-1:0] CNT_ZERO = {DECIM_LOG2{1'b0}};
   localparam logic [DECIM_LOG2-1:0] CNT_ONE  = DECIM_LOG2'(1);
   localparam logic [DECIM_LOG2-1:0] CNT_LAST = DECIM_LOG2'(DECIM - 1);
   localparam logic [ACC_WIDTH-1:0]  ACC_ZERO = {ACC_WIDTH{1'b0}};

   logic                  clr_s;
   logic [ACC_WIDTH-1:0]  din_s [NUM_STAGES];
   logic [ACC_WIDTH-1:0]  acc_s [NUM_STAGES];
   logic [ACC_WIDTH-1:0]  last_next_s;
   logic                  emit_s;
   logic [DECIM_LOG2-1:0] cnt_r;
   logic                  out_valid_r;
   logic [ACC_WIDTH-1:0]  out_data_r;

`ifdef CIC_INTEG_SYNC_CLR_EN
   assign clr_s = sclr;
`else
   assign clr_s = 1'b0;
`endif

   // Stage 0 adds the sign-extended sample; stage k adds the registered
   // (pre-update) value of stage k-1, giving a one-sample pipeline per stage.
   assign din_s[0] = {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};

   genvar k;
   generate
      for (k = 0; k < NUM_STAGES; k++) begin : g_stage
         if (k > 0) begin : g_link
            assign din_s[k] = acc_s[k-1];
         end
         cic_integrator #(
            .ACC_WIDTH (ACC_WIDTH)
         ) u_integ (
            .clk  (clk),
            .rst  (rst),
`ifdef CIC_INTEG_SYNC_CLR_EN
            .sclr (sclr),
`endif
            .en   (in_valid),
            .din  (din_s[k]),
            .acc  (acc_s[k])
         );
      end
   endgenerate

   // Value the last integrator is writing this edge, so the output register
   // captures the post-update sample without waiting an extra cycle.
   always_comb begin
      last_next_s = acc_s[NUM_STAGES-1] + din_s[NUM_STAGES-1];
      emit_s      = in_valid & (cnt_r == CNT_LAST) & ~clr_s;
   end

   // Decimation phase counter 0..DECIM-1; explicit wrap handles non-power-of-two DECIM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= CNT_ZERO;
      end else if (clr_s) begin
         cnt_r <= CNT_ZERO;
      end else if (in_valid) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Output register: strobe for one cycle, data holds between strobes
   // (a synchronous clear only kills the strobe).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= ACC_ZERO;
      end else if (emit_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= last_next_s;
      end else begin
         out_valid_r <= 1'b0;
         out_data_r  <= out_data_r;
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;

endmodule

// File: tb/tb_cic_integ_decim.sv
// -----------------------------------------------------------------------------
// tb_cic_integ_decim
// Scoreboard bench for cic_integ_decim. Three instances share clk/rst:
//   u_dut0 : defaults (N=3, R=8, 25-bit)
//   u_dut1 : N=1, R=4 (18-bit)
//   u_dut5 : N=2, R=5 (non-power-of-two ratio, 22-bit)
// Stimulus pushes {expected data, expected cycle} into a per-instance queue;
// negedge monitors pop and compare whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_cic_integ_decim;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
`ifdef CIC_INTEG_SYNC_CLR_EN
   logic sclr;
`endif

   logic        v0, v1, v5;
   logic [15:0] d0, d1, d5;
   logic        ov0, ov1, ov5;
   logic [24:0] od0;
   logic [17:0] od1;
   logic [21:0] od5;

   typedef struct {
      longint data;
      int     cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q5[$];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   cic_integ_decim u_dut0 (
      .clk(clk), .rst(rst),
`ifdef CIC_INTEG_SYNC_CLR_EN
      .sclr(sclr),
`endif
      .in_valid(v0), .in_data(d0), .out_valid(ov0), .out_data(od0));

   cic_integ_decim #(.DATA_WIDTH(16), .NUM_STAGES(1), .DECIM(4), .DECIM_LOG2(2)) u_dut1 (
      .clk(clk), .rst(rst),
`ifdef CIC_INTEG_SYNC_CLR_EN
      .sclr(1'b0),
`endif
      .in_valid(v1), .in_data(d1), .out_valid(ov1), .out_data(od1));

   cic_integ_decim #(.DATA_WIDTH(16), .NUM_STAGES(2), .DECIM(5), .DECIM_LOG2(3)) u_dut5 (
      .clk(clk), .rst(rst),
`ifdef CIC_INTEG_SYNC_CLR_EN
      .sclr(1'b0),
`endif
      .in_valid(v5), .in_data(d5), .out_valid(ov5), .out_data(od5));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input longint d, input int c);
      exp_t e;
      e.data = d;
      e.cyc  = c;
      return e;
   endfunction

   // Reference for constant input c into 3 pipelined integrators: after
   // valid sample n (0-based) acc2 = c*(n-1)*n*(n+1)/6, reduced mod 2^25.
   function automatic longint ref_const3(input longint c, input longint n);
      longint v;
      v = (c * (n - 1) * n * (n + 1)) / 6;
      v = v & ((64'sd1 <<< 25) - 64'sd1);
      if (v >= (64'sd1 <<< 24)) v = v - (64'sd1 <<< 25);
      return v;
   endfunction

   // Monitors: pop and compare on every observed strobe.
   always @(negedge clk) begin
      if (ov0 === 1'b1) begin
         exp_t e;
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut0_extra: out_valid with data %0d at cycle %0d, expected none", $signed(od0), cyc);
         end else begin
            e = q0.pop_front();
            check("dut0_data", longint'($signed(od0)), e.data);
            check("dut0_cycle", cyc, e.cyc);
            check("dut0_known", longint'($isunknown(od0)), 0);
         end
      end
   end

   always @(negedge clk) begin
      if (ov1 === 1'b1) begin
         exp_t e;
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut1_extra: out_valid with data %0d at cycle %0d, expected none", $signed(od1), cyc);
         end else begin
            e = q1.pop_front();
            check("dut1_data", longint'($signed(od1)), e.data);
            check("dut1_cycle", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (ov5 === 1'b1) begin
         exp_t e;
         if (q5.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut5_extra: out_valid with data %0d at cycle %0d, expected none", $signed(od5), cyc);
         end else begin
            e = q5.pop_front();
            check("dut5_data", longint'($signed(od5)), e.data);
            check("dut5_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic idle_inputs();
      v0 = 1'b0; v1 = 1'b0; v5 = 1'b0;
      d0 = 16'd0; d1 = 16'd0; d5 = 16'd0;
   endtask

   task automatic reset_all();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Let pending strobes appear, then every queue must be empty.
   task automatic drain(input string phase);
      @(negedge clk);
      idle_inputs();
      repeat (4) @(negedge clk);
      check({phase, "_q0_left"}, q0.size(), 0);
      check({phase, "_q1_left"}, q1.size(), 0);
      check({phase, "_q5_left"}, q5.size(), 0);
   endtask

   longint exp5 [3] = '{64'sd10, 64'sd45, 64'sd105};

   initial begin
      int k;
      rst = 1'b1;
`ifdef CIC_INTEG_SYNC_CLR_EN
      sclr = 1'b0;
`endif
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_ov0", longint'(ov0), 0);
      check("rst_od0", longint'(od0), 0);
      check("rst_ov1", longint'(ov1), 0);
      check("rst_od1", longint'(od1), 0);
      check("rst_ov5", longint'(ov5), 0);
      check("rst_od5", longint'(od5), 0);

      // Phase 1: dut0 impulse, dut1 step of 1, dut5 step of 1, all continuous
      reset_all();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         v0 = 1'b1; d0 = (i == 0) ? 16'd1 : 16'd0;
         v1 = (i < 12); d1 = 16'd1;
         v5 = (i < 15); d5 = 16'd1;
         if (i == 7)  q0.push_back(mk(21, cyc + 1));
         if (i == 15) q0.push_back(mk(105, cyc + 1));
         if (i < 12 && (i % 4) == 3) q1.push_back(mk(longint'(i + 1), cyc + 1));
         if (i < 15 && (i % 5) == 4) q5.push_back(mk(exp5[i / 5], cyc + 1));
      end
      drain("p1");

      // Phase 2: dut0 impulse with valid on alternate cycles; dut1 -32768 wrap
      reset_all();
      k = 0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         v0 = ((c % 2) == 0);
         d0 = (v0 && k == 0) ? 16'd1 : 16'd0;
         if (v0) begin
            if (k == 7)  q0.push_back(mk(21, cyc + 1));
            if (k == 15) q0.push_back(mk(105, cyc + 1));
            k++;
         end
         v1 = (c < 8); d1 = 16'h8000;
         if (c == 3) q1.push_back(mk(-131072, cyc + 1));
         if (c == 7) q1.push_back(mk(0, cyc + 1));
         v5 = 1'b0;
      end
      drain("p2");

      // Phase 3: dut0 full-scale positive constant, 200 samples
      reset_all();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         v0 = 1'b1; d0 = 16'sd32767;
         if ((i % 8) == 7) q0.push_back(mk(ref_const3(32767, i), cyc + 1));
      end
      drain("p3");

      // Phase 4: async reset mid-frame (5 samples in), then a fresh frame
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         v0 = 1'b1; d0 = 16'd100;
      end
      @(negedge clk);
      v0 = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_ov0", longint'(ov0), 0);
      check("midrst_od0", longint'(od0), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         v0 = 1'b1; d0 = 16'd1;
         if (i == 7) q0.push_back(mk(56, cyc + 1));
      end
      drain("p4");

`ifdef CIC_INTEG_SYNC_CLR_EN
      // Phase 5: synchronous clear mid-frame, colliding with a valid sample
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         v0 = 1'b1; d0 = 16'd100;
      end
      @(negedge clk);
      v0 = 1'b1; d0 = 16'd100; sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0; v0 = 1'b0;
      check("sclr_ov0", longint'(ov0), 0);
      check("sclr_hold_od0", longint'($signed(od0)), 56);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         v0 = 1'b1; d0 = 16'd1;
         if (i == 7) q0.push_back(mk(56, cyc + 1));
      end
      drain("p5");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cic_integ_decim.md
Name: cic_integ_decim

Overview:
- Integrator-plus-decimator front half of a CIC decimation filter.
- Runs a cascade of NUM_STAGES two's-complement integrators at the input sample rate, then emits every DECIM-th integrated sample with a one-cycle valid strobe.
- Feeds the downstream differentiator (comb) stages. Those run at ACC_WIDTH with a first-difference structure: out = x - x(previous sample).

Parameters:
- DATA_WIDTH, 16: signed input sample width.
- NUM_STAGES, 3: number of cascaded integrators (1..6).
- DECIM, 8: decimation ratio R (2..256).
- DECIM_LOG2, 3: ceil(log2(DECIM)); counter width and bit-growth term.
- ACC_WIDTH (localparam): DATA_WIDTH + NUM_STAGES*DECIM_LOG2 (25 at defaults).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample strobe
- in_data  in  DATA_WIDTH  signed input sample
- out_valid  out  1  decimated sample strobe, one-cycle pulse
- out_data  out  ACC_WIDTH  signed decimated integrator output

Behaviour:
- Reset (async assert, sync release): all integrator accumulators, decimation counter, out_valid and out_data go to 0.
- Integrators, pipelined. On each cycle with in_valid=1:
  - acc0 <= acc0 + sext(in_data)
  - acck <= acck + acc(k-1), using the pre-update (registered) value of acc(k-1), for k=1..NUM_STAGES-1.
- With in_valid=0, all accumulators and the counter hold.
- Arithmetic is modular 2^ACC_WIDTH: wrap-around is intentional, no saturation, no overflow flag. CIC correctness relies on the downstream combs using the same width.
- Decimation counter cnt, 0..DECIM-1:
  - Increments on each in_valid.
  - Wraps to 0 after DECIM-1.
  - Non-power-of-two DECIM must wrap correctly.
- Output: on a cycle with in_valid=1 and cnt==DECIM-1:
  - next cycle out_valid=1
  - out_data = post-update value of acc(NUM_STAGES-1), i.e. the value written that same edge.
- out_valid is 0 otherwise. out_data holds its last value between strobes.
- Latency: one clock from the qualifying in_valid edge to out_valid. An input sample first reaches the last accumulator NUM_STAGES-1 valid samples later (pipelined cascade).
- Back-to-back in_valid every cycle is supported. Maximum out_valid rate is one per DECIM input samples.
- Reset mid-operation discards all partial state. The first out_valid after release occurs on the DECIM-th valid sample.
- No backpressure: the downstream stage must accept out_valid whenever it is asserted.

Optional Feature:
- Macro: CIC_INTEG_SYNC_CLR_EN.
- Defined: adds input port sclr (1 bit). sclr=1 at a clock edge:
  - zeroes all accumulators and cnt
  - forces out_valid=0 next cycle
  - takes priority over in_valid that cycle
  - leaves out_data holding its value.
- Undefined: port absent. Only rst clears state.

Decomposition:
- Package cic_pkg:
  - function computing ACC_WIDTH from (DATA_WIDTH, NUM_STAGES, DECIM_LOG2)
  - limits NUM_STAGES_MAX=6 and DECIM_MAX=256
  - shared so the comb block sizes identically.
- Sub-module cic_integrator:
  - one ACC_WIDTH enabled accumulator, with async rst and optional sclr
  - instantiated NUM_STAGES times in a generate loop.
- The decimation counter and output register stay in the top level.

Test Plan:
- NUM_STAGES=1, DECIM=4, in_data=1 every cycle -> out_valid on valid samples 3,7,11; out_data=4,8,12.
- Defaults, impulse in_data=1 at sample 0 then zeros, in_valid continuous -> out_data=21 at sample 7, 105 at sample 15 (acc2(n)=n(n-1)/2).
- Repeat the impulse test with in_valid low on alternate cycles -> identical out_data sequence; out_valid appears only one clock after the 8th/16th valid sample.
- NUM_STAGES=1, DECIM=4, in_data=-32768 constant -> out_data=-131072, then wrap to 0 on the next output (18-bit modular).
- Defaults, in_data=32767 constant for 200 samples -> every out_data matches a modulo-2^25 reference model; no X.
- rst pulsed mid-frame (after 5 valid samples) -> outputs 0 immediately; the next out_valid follows exactly 8 valid samples later, matching a fresh run. With CIC_INTEG_SYNC_CLR_EN, the same check applies using sclr.
